// File: rtl/jtag_pkg.sv
// rtl/jtag_pkg.sv - shared JTAG TAP state encodings and opcode constants
package jtag_pkg;

  // Standard IEEE 1149.1 4-bit state encoding
  typedef enum logic [3:0] {
    EX2_DR   = 4'h0,
    EX1_DR   = 4'h1,
    SH_DR    = 4'h2,
    PAUSE_DR = 4'h3,
    SEL_IR   = 4'h4,
    UPD_DR   = 4'h5,
    CAP_DR   = 4'h6,
    SEL_DR   = 4'h7,
    EX2_IR   = 4'h8,
    EX1_IR   = 4'h9,
    SH_IR    = 4'hA,
    PAUSE_IR = 4'hB,
    RTI      = 4'hC,
    UPD_IR   = 4'hD,
    CAP_IR   = 4'hE,
    TLR      = 4'hF
  } tap_state_t;

  localparam logic [3:0] OP_IDCODE = 4'b0001;
  localparam logic [3:0] OP_BYPASS = 4'b1111;
  localparam logic [3:0] OP_SAMPLE = 4'b0010;

  function automatic logic is_shift_state(input tap_state_t s);
    return (s == SH_IR) || (s == SH_DR);
  endfunction

endpackage

// File: rtl/tap_fsm.sv
// rtl/tap_fsm.sv - 16-state TAP state register and TMS-driven next-state logic
module tap_fsm
  import jtag_pkg::*;
(
  input  logic       TCK,
  input  logic       TRST_n,
  input  logic       TMS,
  output tap_state_t state
);

  tap_state_t next_state;

  always_ff @(posedge TCK or negedge TRST_n) begin
    if (!TRST_n) state <= TLR;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      TLR:      next_state = TMS ? TLR      : RTI;
      RTI:      next_state = TMS ? SEL_DR   : RTI;
      SEL_DR:   next_state = TMS ? SEL_IR   : CAP_DR;
      CAP_DR:   next_state = TMS ? EX1_DR   : SH_DR;
      SH_DR:    next_state = TMS ? EX1_DR   : SH_DR;
      EX1_DR:   next_state = TMS ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: next_state = TMS ? EX2_DR   : PAUSE_DR;
      EX2_DR:   next_state = TMS ? UPD_DR   : SH_DR;
      UPD_DR:   next_state = TMS ? SEL_DR   : RTI;
      SEL_IR:   next_state = TMS ? TLR      : CAP_IR;
      CAP_IR:   next_state = TMS ? EX1_IR   : SH_IR;
      SH_IR:    next_state = TMS ? EX1_IR   : SH_IR;
      EX1_IR:   next_state = TMS ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: next_state = TMS ? EX2_IR   : PAUSE_IR;
      EX2_IR:   next_state = TMS ? UPD_IR   : SH_IR;
      UPD_IR:   next_state = TMS ? SEL_DR   : RTI;
      default:  next_state = TLR;
    endcase
  end

endmodule

// File: rtl/tap_controller.sv
// rtl/tap_controller.sv - JTAG TAP controller: IR, opcode decode, bypass register and TDO mux
module tap_controller
  import jtag_pkg::*;
#(
  parameter int              IR_W      = 4,
  parameter logic [IR_W-1:0] IDCODE_OP = IR_W'(OP_IDCODE),
  parameter logic [IR_W-1:0] BYPASS_OP = IR_W'(OP_BYPASS),
  parameter logic [IR_W-1:0] SAMPLE_OP = IR_W'(OP_SAMPLE)
) (
  input  logic            TCK,
  input  logic            TRST_n,
  input  logic            TMS,
  input  logic            TDI,
  output logic            TDO,
  output logic            TDO_en,
  input  logic            ID_tdo,
  input  logic            BSR_tdo,
  output logic            Shift_DR,
  output logic            ID_clk_en,
  output logic            BSR_clk_en,
  output logic            Update_DR,
  output logic [IR_W-1:0] IR_q,
  output logic [3:0]      TAP_state
);

  tap_state_t      state;
  logic [IR_W-1:0] ir_shift;
  logic            bypass_q;
  logic            is_idcode;
  logic            is_sample;
  logic            is_bypass;
  logic            dr_active;
  logic            dr_src;

  tap_fsm u_fsm (
    .TCK    (TCK),
    .TRST_n (TRST_n),
    .TMS    (TMS),
    .state  (state)
  );

  assign TAP_state = state;

  // An explicit BYPASS opcode wins; anything not IDCODE/SAMPLE falls back to bypass
  assign is_idcode = (IR_q == IDCODE_OP);
  assign is_sample = (IR_q == SAMPLE_OP);
  assign is_bypass = (IR_q == BYPASS_OP) || !(is_idcode || is_sample);

  assign dr_active  = (state == CAP_DR) || (state == SH_DR);
  assign Shift_DR   = (state == SH_DR);
  assign Update_DR  = (state == UPD_DR);
  assign ID_clk_en  = dr_active && is_idcode && !is_bypass;
  assign BSR_clk_en = dr_active && is_sample && !is_bypass;

  assign dr_src = is_bypass ? bypass_q : (is_sample ? BSR_tdo : ID_tdo);

  always_ff @(posedge TCK or negedge TRST_n) begin
    if (!TRST_n) begin
      IR_q     <= IDCODE_OP;
      ir_shift <= '0;
    end else begin
      case (state)
        TLR:     IR_q     <= IDCODE_OP;
        CAP_IR:  ir_shift <= IR_W'(1);
        SH_IR:   ir_shift <= {TDI, ir_shift[IR_W-1:1]};
        UPD_IR:  IR_q     <= ir_shift;
        default: ;
      endcase
    end
  end

  always_ff @(posedge TCK or negedge TRST_n) begin
    if (!TRST_n) begin
      bypass_q <= 1'b0;
    end else if (state == CAP_DR) begin
      bypass_q <= 1'b0;
    end else if (state == SH_DR) begin
      bypass_q <= TDI;
    end
  end

  // TDO keeps its last value outside the shift states so pauses do not disturb it
  always_ff @(posedge TCK or negedge TRST_n) begin
    if (!TRST_n) begin
      TDO    <= 1'b0;
      TDO_en <= 1'b0;
    end else begin
      TDO_en <= is_shift_state(state);
      if (state == SH_IR)      TDO <= ir_shift[0];
      else if (state == SH_DR) TDO <= dr_src;
    end
  end

endmodule
